// File: rtl/uart_proto_pkg.sv
// uart_proto_pkg
//   Protocol constants and the responder state encoding shared between the
//   device-side dump responder and the host-side model that talks to it.
//   READY_BYTE_DEF : prompt byte sent after reset and after every command
//   CMD_DUMP_DEF   : command byte that starts a memory dump
//   state_e        : responder state encoding
package uart_proto_pkg;

  localparam logic [7:0] READY_BYTE_DEF = 8'h2E;  // '.'
  localparam logic [7:0] CMD_DUMP_DEF   = 8'h44;  // 'D'

  typedef enum logic [2:0] {
    ST_PROMPT   = 3'd0,
    ST_IDLE     = 3'd1,
    ST_GET_ADDR = 3'd2,
    ST_GET_LEN  = 3'd3,
    ST_MEM_RD   = 3'd4,
    ST_SEND     = 3'd5,
    ST_TX_GAP   = 3'd6
  } state_e;

endpackage

// File: rtl/uart_dump_responder.sv
// uart_dump_responder
//   Sends a prompt byte, then waits for a dump command followed by a 32-bit
//   start address and a 32-bit byte count (both little-endian). The requested
//   bytes are fetched one 32-bit word at a time and streamed out LSB first;
//   the prompt is sent again when the dump is finished.
//
// Ports
//   clk, rst_n           : clock; rst_n is a synchronous ACTIVE-HIGH reset
//   rx_data_ready/rx_data: byte from the UART receiver
//   rx_clear             : one-cycle pulse consuming the received byte
//   tx_busy              : UART transmitter busy
//   tx_start/tx_data     : one-cycle launch pulse and byte to transmit
//   mem_req/mem_addr     : word read request (held until mem_ack)
//   mem_ack/mem_rdata    : read completion and data
//   busy                 : high from the first address byte to end of dump
module uart_dump_responder
  import uart_proto_pkg::*;
#(
  parameter logic [7:0] READY_BYTE = READY_BYTE_DEF,
  parameter logic [7:0] CMD_DUMP   = CMD_DUMP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_data_ready,
  input  logic [7:0]  rx_data,
  output logic        rx_clear,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:2] addr_q, addr_d;          // low address bits are never stored
  logic [31:0] len_q, len_d;            // length while receiving, then bytes remaining
  logic [31:0] word_addr_q, word_addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  idx_q, idx_d;
  logic        ret_idle_q, ret_idle_d;  // TX_GAP after the prompt returns to IDLE
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rx_clear_q, rx_clear_d;
  logic        mem_req_q, mem_req_d;
  logic        busy_q, busy_d;

  logic        rx_take;
  logic [31:0] len_full;

  // The receiver drops rx_data_ready on the edge that sees rx_clear, so the
  // byte is still flagged during the rx_clear cycle and must not be taken twice.
  assign rx_take  = rx_data_ready && !rx_clear_q;
  assign len_full = {rx_data, len_q[23:0]};

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    len_d       = len_q;
    word_addr_d = word_addr_q;
    rdata_d     = rdata_q;
    idx_d       = idx_q;
    ret_idle_d  = ret_idle_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    rx_clear_d  = 1'b0;
    mem_req_d   = mem_req_q;
    busy_d      = busy_q;

    // Every received byte is consumed, whatever the state; only IDLE and
    // the GET states make use of it.
    if (rx_take) begin
      rx_clear_d = 1'b1;
    end

    case (state_q)
      ST_PROMPT: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = READY_BYTE;
          ret_idle_d = 1'b1;
          state_d    = ST_TX_GAP;
        end
      end

      ST_IDLE: begin
        if (rx_take && rx_data == CMD_DUMP) begin
          byte_cnt_d = 2'd0;
          state_d    = ST_GET_ADDR;
        end
      end

      ST_GET_ADDR: begin
        if (rx_take) begin
          busy_d = 1'b1;
          case (byte_cnt_q)
            2'd0:    addr_d[7:2]   = rx_data[7:2];
            2'd1:    addr_d[15:8]  = rx_data;
            2'd2:    addr_d[23:16] = rx_data;
            default: addr_d[31:24] = rx_data;
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = ST_GET_LEN;
          end
        end
      end

      ST_GET_LEN: begin
        if (rx_take) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q != 2'd3) begin
            len_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
          end else begin
            len_d = len_full;
            if (len_full == 32'd0) begin
              busy_d  = 1'b0;
              state_d = ST_PROMPT;
            end else begin
              word_addr_d = {addr_q, 2'b00};
              mem_req_d   = 1'b1;
              state_d     = ST_MEM_RD;
            end
          end
        end
      end

      ST_MEM_RD: begin
        if (mem_ack) begin
          rdata_d   = mem_rdata;
          mem_req_d = 1'b0;
          idx_d     = 2'd0;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = rdata_q[{idx_q, 3'b000} +: 8];
          len_d      = len_q - 32'd1;
          state_d    = ST_TX_GAP;
        end
      end

      ST_TX_GAP: begin
        // One cycle for the transmitter to raise tx_busy after tx_start.
        if (ret_idle_q) begin
          ret_idle_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (len_q == 32'd0) begin
          busy_d  = 1'b0;
          state_d = ST_PROMPT;
        end else if (idx_q == 2'd3) begin
          word_addr_d = word_addr_q + 32'd4;  // wraps modulo 2^32
          mem_req_d   = 1'b1;
          state_d     = ST_MEM_RD;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_SEND;
        end
      end

      default: begin
        state_d = ST_PROMPT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_PROMPT;
      byte_cnt_q  <= 2'd0;
      addr_q      <= '0;
      len_q       <= '0;
      word_addr_q <= '0;
      rdata_q     <= '0;
      idx_q       <= 2'd0;
      ret_idle_q  <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      rx_clear_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      word_addr_q <= word_addr_d;
      rdata_q     <= rdata_d;
      idx_q       <= idx_d;
      ret_idle_q  <= ret_idle_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      rx_clear_q  <= rx_clear_d;
      mem_req_q   <= mem_req_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_clear = rx_clear_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = word_addr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_dump_responder.sv
module tb_uart_dump_responder;
  import uart_proto_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_data_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_clear;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  always #5 clk = ~clk;

  uart_dump_responder dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data_ready(rx_data_ready), .rx_data(rx_data), .rx_clear(rx_clear),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  int checks = 0;
  int passes = 0;

  logic [7:0]  exp_tx[$];
  logic [7:0]  obs_tx[$];
  logic [31:0] exp_addr[$];
  logic [31:0] obs_addr[$];
  int          obs_req_len[$];

  int start_while_busy = 0;
  int start_during_req = 0;
  int rx_clear_cnt = 0;
  int rx_timeouts = 0;
  int mem_delay = 0;
  int busy_cnt = 0;
  bit in_req = 1'b0;
  int wait_cnt = 0;
  int req_len = 0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'h80100000: return 32'h03020100;
      32'h80100004: return 32'h07060504;
      32'h80100008: return 32'h0B0A0908;
      32'hFFFFFFFC: return 32'hDDCCBBAA;
      32'h00000000: return 32'h44332211;
      default:      return ~a;
    endcase
  endfunction

  // Transmitter model: records each launched byte, raises busy on the edge
  // after tx_start and keeps it for four cycles.
  always @(negedge clk) begin
    if (rx_clear) rx_clear_cnt++;
    if (tx_start) begin
      obs_tx.push_back(tx_data);
      if (tx_busy) start_while_busy++;
      if (mem_req) start_during_req++;
      busy_cnt = 4;
      tx_busy = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
  end

  // Memory model: acknowledges each request after mem_delay extra cycles.
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (!mem_req) begin
      in_req = 1'b0;
    end else begin
      if (!in_req) begin
        in_req = 1'b1;
        wait_cnt = mem_delay;
        req_len = 0;
        obs_addr.push_back(mem_addr);
      end
      req_len++;
      if (wait_cnt == 0) begin
        mem_ack = 1'b1;
        mem_rdata = mem_read(mem_addr);
        in_req = 1'b0;
        obs_req_len.push_back(req_len);
      end else begin
        wait_cnt--;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_data = b;
    rx_data_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_clear && n < 50);
    if (!rx_clear) rx_timeouts++;
    rx_data_ready = 1'b0;
  endtask

  task automatic send_dump(input logic [31:0] addr, input logic [31:0] len);
    send_byte(CMD_DUMP_DEF);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
  endtask

  // Scoreboard expectations for a dump: data bytes, word addresses, prompt.
  task automatic push_expect(input logic [31:0] addr, input int len);
    logic [31:0] base;
    logic [31:0] wa;
    logic [31:0] word;
    base = {addr[31:2], 2'b00};
    for (int i = 0; i < len; i++) begin
      wa = base + 32'(4 * (i / 4));
      word = mem_read(wa);
      if (i % 4 == 0) exp_addr.push_back(wa);
      exp_tx.push_back(word[8*(i%4) +: 8]);
    end
    exp_tx.push_back(READY_BYTE_DEF);
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    while ((obs_tx.size() < exp_tx.size() || obs_addr.size() < exp_addr.size()) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 3000);
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    bit ok;
    logic [7:0] e, o;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_start, rx_clear, mem_req, busy} !== 4'b0 || tx_data !== 8'h00 || mem_addr !== 32'h0)
      $display("FAIL reset_outputs: got start=%b clr=%b req=%b busy=%b data=%h addr=%h want all zero",
               tx_start, rx_clear, mem_req, busy, tx_data, mem_addr);
    else passes++;
    rst_n = 1'b0;
    exp_tx.push_back(READY_BYTE_DEF);
    wait_done(ok);
    checks++;
    if (!ok) $display("FAIL reset_prompt_timeout: got %0d bytes want %0d", obs_tx.size(), exp_tx.size());
    else passes++;
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front();
      if (obs_tx.size() > 0) o = obs_tx.pop_front(); else o = 8'hxx;
      checks++;
      if (o !== e) $display("FAIL reset_prompt_byte: got %h want %h", o, e); else passes++;
    end
    checks++;
    if (obs_tx.size() != 0 || busy !== 1'b0)
      $display("FAIL reset_idle: got extra=%0d busy=%b want 0 and 0", obs_tx.size(), busy);
    else passes++;
  endtask

  task automatic test_idle_junk();
    int c0;
    c0 = rx_clear_cnt;
    send_byte(8'h41);
    repeat (20) @(negedge clk);
    checks++;
    if (rx_clear_cnt - c0 != 1) $display("FAIL junk_rx_clear: got %0d pulses want 1", rx_clear_cnt - c0);
    else passes++;
    checks++;
    if (obs_tx.size() != 0 || obs_addr.size() != 0 || busy !== 1'b0)
      $display("FAIL junk_no_effect: got tx=%0d req=%0d busy=%b want 0 0 0", obs_tx.size(), obs_addr.size(), busy);
    else passes++;
  endtask

  task automatic test_dump(input string name, input logic [31:0] addr, input logic [31:0] len,
                           input int delay, input bit inject_rx);
    bit ok;
    int n;
    logic [7:0] e, o;
    logic [31:0] ea, oa;
    int rl;
    mem_delay = delay;
    obs_req_len.delete();
    push_expect(addr, int'(len));
    send_dump(addr, len);
    checks++;
    if (busy !== (len != 0)) $display("FAIL %s busy_during: got %b want %b", name, busy, (len != 0));
    else passes++;
    if (inject_rx) begin
      n = 0;
      while (obs_tx.size() < 2 && n < 500) begin @(negedge clk); n++; end
      send_byte(CMD_DUMP_DEF);  // must be discarded mid-dump
    end
    wait_done(ok);
    checks++;
    if (!ok) $display("FAIL %s timeout: got %0d bytes want %0d", name, obs_tx.size(), exp_tx.size());
    else passes++;
    while (exp_addr.size() > 0) begin
      ea = exp_addr.pop_front();
      if (obs_addr.size() > 0) oa = obs_addr.pop_front(); else oa = 32'hxxxxxxxx;
      checks++;
      if (oa !== ea) $display("FAIL %s mem_addr: got %h want %h", name, oa, ea); else passes++;
    end
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front();
      if (obs_tx.size() > 0) o = obs_tx.pop_front(); else o = 8'hxx;
      checks++;
      if (o !== e) $display("FAIL %s tx_byte: got %h want %h", name, o, e); else passes++;
    end
    while (obs_req_len.size() > 0) begin
      rl = obs_req_len.pop_front();
      checks++;
      if (rl != delay + 1) $display("FAIL %s mem_req_hold: got %0d cycles want %0d", name, rl, delay + 1);
      else passes++;
    end
    checks++;
    if (obs_tx.size() != 0 || obs_addr.size() != 0 || busy !== 1'b0 || start_during_req != 0)
      $display("FAIL %s after: got extra_tx=%0d extra_req=%0d busy=%b start_in_req=%0d want 0 0 0 0",
               name, obs_tx.size(), obs_addr.size(), busy, start_during_req);
    else passes++;
    mem_delay = 0;
  endtask

  task automatic test_reset_mid_dump();
    bit ok;
    int n;
    logic [7:0] e, o;
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h02);
    exp_tx.push_back(READY_BYTE_DEF);
    send_dump(32'h80100000, 32'd8);
    n = 0;
    while (obs_tx.size() < 3 && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_start, mem_req, busy} !== 3'b0)
      $display("FAIL midreset_outputs: got start=%b req=%b busy=%b want 0 0 0", tx_start, mem_req, busy);
    else passes++;
    rst_n = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) $display("FAIL midreset_timeout: got %0d bytes want %0d", obs_tx.size(), exp_tx.size());
    else passes++;
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front();
      if (obs_tx.size() > 0) o = obs_tx.pop_front(); else o = 8'hxx;
      checks++;
      if (o !== e) $display("FAIL midreset_tx_byte: got %h want %h", o, e); else passes++;
    end
    checks++;
    if (obs_tx.size() != 0 || obs_addr.size() != 1)
      $display("FAIL midreset_abandon: got extra_tx=%0d requests=%0d want 0 and 1", obs_tx.size(), obs_addr.size());
    else passes++;
    obs_addr.delete();
  endtask

  initial begin
    test_reset();
    test_idle_junk();
    test_dump("dump_basic", 32'h80100010 - 32'h10, 32'd8, 0, 1'b0);
    test_dump("dump_unaligned", 32'h80100003, 32'd5, 0, 1'b1);
    test_dump("dump_len_zero", 32'h80100000, 32'd0, 0, 1'b0);
    test_dump("dump_wrap_delay", 32'hFFFFFFFC, 32'd8, 10, 1'b0);
    test_reset_mid_dump();
    test_dump("dump_after_reset", 32'h80100004, 32'd6, 2, 1'b0);
    checks++;
    if (start_while_busy != 0 || rx_timeouts != 0)
      $display("FAIL protocol: got start_while_busy=%0d rx_timeouts=%0d want 0 0", start_while_busy, rx_timeouts);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_dump_responder.md
UART_DUMP_RESPONDER -- requirements
Module: uart_dump_responder

Interface
REQ-001 SHALL have parameter READY_BYTE, default 8'h2E, meaning the prompt byte transmitted after reset and after each command.
REQ-002 SHALL have parameter CMD_DUMP, default 8'h44 ('D'), meaning the memory-dump command byte.
REQ-003 clk  input  1  single clock; all logic is on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-high (1 = reset).
REQ-005 rx_data_ready  input  1  received byte is valid (from async_receiver).
REQ-006 rx_data  input  8  received byte.
REQ-007 rx_clear  output  1  one-cycle pulse that consumes the received byte.
REQ-008 tx_busy  input  1  transmitter busy (from async_transmitter).
REQ-009 tx_start  output  1  one-cycle pulse that launches tx_data.
REQ-010 tx_data  output  8  byte to transmit; held stable while tx_start=1.
REQ-011 mem_req  output  1  word read request; held until mem_ack.
REQ-012 mem_addr  output  32  word-aligned read address, with [1:0]=2'b00.
REQ-013 mem_ack  input  1  read data valid this cycle; ends the request.
REQ-014 mem_rdata  input  32  read data, sampled when mem_ack=1.
REQ-015 busy  output  1  high from the first address byte until the dump ends.

Function
REQ-016 States: PROMPT, IDLE, GET_ADDR, GET_LEN, MEM_RD, SEND, TX_GAP.
REQ-017 PROMPT: when tx_busy=0, pulse tx_start with tx_data=READY_BYTE, then go to TX_GAP with return state IDLE.
REQ-018 IDLE: on rx_data_ready, pulse rx_clear; rx_data==CMD_DUMP -> GET_ADDR; any other byte -> stay in IDLE, no transmit.
REQ-019 GET_ADDR / GET_LEN: accept 4 bytes each, little-endian (first byte -> [7:0]), with a 2-bit byte counter; every accepted byte gets an rx_clear pulse.
REQ-020 After the 4th length byte: len==0 -> PROMPT with no memory access; otherwise word_addr={addr[31:2],2'b00} -> MEM_RD.
REQ-021 addr[1:0] SHALL be ignored; the dump always starts at a byte-0 word boundary.
REQ-022 MEM_RD: assert mem_req with mem_addr=word_addr; on mem_ack, latch mem_rdata, deassert mem_req the next cycle, byte index=0 -> SEND.
REQ-023 SEND: when tx_busy=0, pulse tx_start with byte[index] (index 0 = [7:0]), decrement the remaining count, -> TX_GAP.
REQ-024 TX_GAP: exactly one wait cycle before tx_busy is sampled again, so a start is never issued before busy rises. Then: remaining==0 -> PROMPT; index==3 -> word_addr+=4, MEM_RD; otherwise index+=1 -> SEND.
REQ-025 Exactly len bytes SHALL be sent; a final partial word sends only its low bytes.
REQ-026 word_addr SHALL wrap modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000).
REQ-027 rx_data_ready during PROMPT/MEM_RD/SEND/TX_GAP: the byte is discarded with an rx_clear pulse and has no other effect.
REQ-028 tx_start, rx_clear and mem_req SHALL be registered outputs; at most one tx_start per TX_GAP cycle.
REQ-029 Dump latency: first tx_start no earlier than 1 cycle after mem_ack, and in the first cycle with tx_busy=0 after that.

Reset
REQ-030 When rst_n=1 at a clk edge: state=PROMPT, tx_start=0, tx_data=0, rx_clear=0, mem_req=0, mem_addr=0, busy=0, counters and registers=0.
REQ-031 Reset mid-dump SHALL abandon the dump immediately, with no further mem_req or tx_start.
REQ-032 The prompt SHALL be re-sent after reset is released.

Structure
REQ-033 State encoding, READY_BYTE and CMD_DUMP SHALL live in a shared package uart_proto_pkg, also used by the host-side model.
REQ-034 Single module, no sub-modules; the UART PHYs are instantiated by the parent.

Verification
REQ-035 Reset, tx_busy=0 -> one tx_start with 8'h2E, then IDLE with busy=0.
REQ-036 Rx 44,00,00,10,80,08,00,00,00; memory [0x80100000]=0x03020100, [0x80100004]=0x07060504 -> mem_addr 0x80100000 then 0x80100004; tx bytes 00..07, then 2E.
REQ-037 Dump at 0x80100003 with len=5, same memory -> start address 0x80100000; tx 00,01,02,03,04 (word 2 byte 0 only), then 2E.
REQ-038 Len=0 -> no mem_req; next tx byte is 2E. Rx byte 0x41 in IDLE -> rx_clear pulse, no tx.
REQ-039 Address 0xFFFFFFFC, len=8 -> mem_addr 0xFFFFFFFC then 0x00000000. mem_ack delayed 10 cycles -> mem_req held for all 10, no tx_start meanwhile.
REQ-040 rst_n pulsed during SEND of byte 3 -> no further data bytes; next tx byte is 2E.
